// File: rtl/data_mem_ctrl.sv
// Single-port word memory with a fixed-latency read pipeline and a full-array
// zero-fill sweep that runs after reset and on request.
module data_mem_ctrl #(
  parameter int D   = 8,
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         we,
  input  logic [D-1:0] addr,
  input  logic [W-1:0] din,
  input  logic         clear,
  output logic         ready,
  output logic         rvalid,
  output logic [W-1:0] dout,
  output logic         busy
);

  localparam logic [0:0]   S_IDLE   = 1'b0;
  localparam logic [0:0]   S_CLEAR  = 1'b1;
  localparam logic [D-1:0] CNT_LAST = {D{1'b1}};
  localparam logic [D-1:0] CNT_ONE  = {{(D-1){1'b0}}, 1'b1};

  logic [0:0]   r_state;
  logic [D-1:0] r_cnt;
  logic [W-1:0] r_mem [2**D];
  logic [LAT-1:0] r_vld;
  logic [W-1:0] r_pdat [LAT];

  logic         w_accept;
  logic         w_rd;
  logic         w_mem_we;
  logic [D-1:0] w_mem_addr;
  logic [W-1:0] w_mem_wdata;

  // Handshake decode and the single memory write port shared by sweep and requests
  always_comb begin
    ready       = (r_state == S_IDLE) && !clear;
    busy        = (r_state == S_CLEAR);
    w_accept    = ready && req;
    w_rd        = w_accept && !we;
    w_mem_we    = 1'b0;
    w_mem_addr  = addr;
    w_mem_wdata = din;
    case (r_state)
      S_CLEAR: begin
        w_mem_we    = rst_n;
        w_mem_addr  = r_cnt;
        w_mem_wdata = {W{1'b0}};
      end
      S_IDLE: begin
        w_mem_we    = w_accept && we;
        w_mem_addr  = addr;
        w_mem_wdata = din;
      end
      default: begin
        w_mem_we    = 1'b0;
        w_mem_addr  = addr;
        w_mem_wdata = din;
      end
    endcase
  end

  // Sweep FSM: reset lands in CLEAR so every release zero-fills the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= {D{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_state <= S_CLEAR;
            r_cnt   <= {D{1'b0}};
          end
        end
        S_CLEAR: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_cnt   <= {D{1'b0}};
        end
      endcase
    end
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Read pipeline; a stage's data only moves with its valid so dout holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= {LAT{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        r_pdat[i] <= {W{1'b0}};
      end
    end else begin
      r_vld[0] <= w_rd;
      if (w_rd) begin
        r_pdat[0] <= r_mem[addr];
      end
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_pdat[i] <= r_pdat[i-1];
        end
      end
    end
  end

  assign rvalid = r_vld[LAT-1];
  assign dout   = r_pdat[LAT-1];

endmodule
